// File: rtl/mem_line_responder.sv
// Memory-side line responder: a line-granular backing store that answers one
// fill (read) or eviction (write) at a time, a fixed number of cycles after
// the request is accepted. The requester sees a busy/ack handshake.
module mem_line_responder #(
  parameter int cache_line_width   = 256,
  parameter int addr_width         = 16,
  parameter int num_bytes_per_line = 32,
  parameter int mem_lines          = 256,
  parameter int mem_latency        = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_req,
  input  logic                        mem_we,
  input  logic [addr_width-1:0]       mem_addr,
  input  logic [cache_line_width-1:0] mem_wdata,
  output logic [cache_line_width-1:0] mem_rdata,
  output logic                        mem_busy,
  output logic                        mem_ack
);

  localparam int OFF_W = $clog2(num_bytes_per_line);
  localparam int IDX_W = $clog2(mem_lines);
  localparam logic [7:0] LAT_M1 = 8'(mem_latency - 1);
  // Address bits that select the line; everything else aliases.
  localparam logic [addr_width-1:0] IDX_MASK = addr_width'(mem_lines - 1) << OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                      state, state_n;
  logic [7:0]                  cnt, cnt_n;
  logic                        lat_we;
  logic [IDX_W-1:0]            lat_idx;
  logic [cache_line_width-1:0] lat_wdata;
  logic [cache_line_width-1:0] mem_array [mem_lines];

  logic             accept;
  logic             ack_entry;
  logic             rd_we;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             unused_addr;

  assign req_idx     = mem_addr[OFF_W +: IDX_W];
  assign unused_addr = ^(mem_addr & ~IDX_MASK);

  // Next-state, counter and ACK-entry decode. With a latency of one the
  // request goes straight to ACK, so the read source is the live request.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: if (mem_req) begin
        cnt_n   = LAT_M1;
        state_n = (mem_latency == 1) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        cnt_n = cnt - 8'd1;
        if (cnt == 8'd1) state_n = S_ACK;
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    accept    = (state == S_IDLE) && mem_req;
    ack_entry = (state_n == S_ACK) && (state != S_ACK);
    rd_we     = accept ? mem_we  : lat_we;
    rd_idx    = accept ? req_idx : lat_idx;
  end

  // State, counter, latched request and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      mem_busy  <= 1'b0;
      mem_ack   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mem_busy <= (state_n != S_IDLE);
      mem_ack  <= (state_n == S_ACK);
      if (accept) begin
        lat_we    <= mem_we;
        lat_idx   <= req_idx;
        lat_wdata <= mem_wdata;
      end
    end
  end

  // Read data is captured on entry to ACK and held until the next read ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  mem_rdata <= '0;
    else if (ack_entry && !rd_we) mem_rdata <= mem_array[rd_idx];
  end

  // Eviction data lands at the end of the ACK cycle; a reset drops state to
  // IDLE asynchronously, so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (state == S_ACK && lat_we) mem_array[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: a latency-5 and a latency-1 instance checked
// against a line-array model, with table vectors, corner sequences and
// randomized traffic.
module tb_mem_line_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         req5, we5, busy5, ack5;
  logic [15:0]  addr5;
  logic [255:0] wdata5, rdata5;
  logic         req1, we1, busy1, ack1;
  logic [15:0]  addr1;
  logic [255:0] wdata1, rdata1;

  mem_line_responder #(.mem_latency(5)) d5 (
    .clk(clk), .reset(reset), .mem_req(req5), .mem_we(we5), .mem_addr(addr5),
    .mem_wdata(wdata5), .mem_rdata(rdata5), .mem_busy(busy5), .mem_ack(ack5));

  mem_line_responder #(.mem_latency(1)) d1 (
    .clk(clk), .reset(reset), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1), .mem_busy(busy1), .mem_ack(ack1));

  // Model: [0] tracks the latency-5 instance, [1] the latency-1 instance.
  logic [255:0] mem_m [2][256];
  logic [255:0] rmod [2];
  int tests = 0;
  int fails = 0;

  typedef struct {
    bit           we;
    logic [15:0]  addr;
    logic [255:0] data;
    logic [255:0] exp_rdata;
  } vec_t;

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] fill(input logic [7:0] b);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic get_busy(input int lat);
    return (lat == 5) ? busy5 : busy1;
  endfunction
  function automatic logic get_ack(input int lat);
    return (lat == 5) ? ack5 : ack1;
  endfunction
  function automatic logic [255:0] get_rdata(input int lat);
    return (lat == 5) ? rdata5 : rdata1;
  endfunction

  task automatic drive(input int lat, input bit r, input bit w, input logic [15:0] a,
                       input logic [255:0] d);
    if (lat == 5) begin req5 = r; we5 = w; addr5 = a; wdata5 = d; end
    else          begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic drive_idle(input int lat);
    drive(lat, 1'b0, 1'($urandom), 16'($urandom), rnd_line());
  endtask

  // One transaction starting in cycle 0 (called just after a rising edge).
  // ign != 0 places a stray request in that busy cycle; it must be ignored.
  task automatic txn(input int lat, input bit w, input logic [15:0] a, input logic [255:0] d,
                     input int ign, input logic [15:0] ia, output logic [255:0] got);
    int s   = (lat == 5) ? 0 : 1;
    int idx = (int'(a) / 32) % 256;
    got = '0;
    drive(lat, 1'b1, w, a, d);
    @(negedge clk);
    chk("idle_busy", {255'b0, get_busy(lat)}, 256'd0);
    chk("idle_ack",  {255'b0, get_ack(lat)},  256'd0);
    @(posedge clk); #1;
    for (int c = 1; c <= lat; c++) begin
      if (c == ign) drive(lat, 1'b1, 1'($urandom), ia, rnd_line());
      else          drive_idle(lat);
      @(negedge clk);
      chk("busy", {255'b0, get_busy(lat)}, 256'd1);
      chk("ack",  {255'b0, get_ack(lat)},  {255'b0, (c == lat)});
      if (c == lat) begin
        if (!w) rmod[s] = mem_m[s][idx];
        got = get_rdata(lat);
        chk("rdata", got, rmod[s]);
      end
      @(posedge clk); #1;
    end
    drive_idle(lat);
    if (w) mem_m[s][idx] = d;
  endtask

  vec_t         vt [$];
  logic [255:0] got;
  logic [255:0] dz, dx, dy;

  initial begin
    for (int s = 0; s < 2; s++) begin
      rmod[s] = '0;
      for (int i = 0; i < 256; i++) mem_m[s][i] = '0;
    end
    drive_idle(5);
    drive_idle(1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy5",  {255'b0, busy5}, 256'd0);
    chk("rst_ack5",   {255'b0, ack5},  256'd0);
    chk("rst_rdata5", rdata5, 256'd0);
    chk("rst_busy1",  {255'b0, busy1}, 256'd0);
    chk("rst_rdata1", rdata1, 256'd0);
    @(posedge clk); #1;

    // Array contents are not reset; give both instances a known zero image.
    for (int i = 0; i < 256; i++) txn(5, 1'b1, 16'(i * 32), '0, 0, '0, got);
    for (int i = 0; i < 256; i++) txn(1, 1'b1, 16'(i * 32), '0, 0, '0, got);

    // Table vectors: write/read, line-index aliasing and ignored offset bits.
    dx = rnd_line();
    dy = rnd_line();
    dz = rnd_line();
    vt.push_back('{1'b1, 16'h0040, fill(8'hA5), '0});
    vt.push_back('{1'b0, 16'h0040, '0, fill(8'hA5)});
    vt.push_back('{1'b1, 16'h0000, dx, '0});
    vt.push_back('{1'b1, 16'h2000, dy, '0});
    vt.push_back('{1'b0, 16'h0000, '0, dy});
    vt.push_back('{1'b0, 16'h001F, '0, dy});
    vt.push_back('{1'b1, 16'h0020, dz, '0});
    vt.push_back('{1'b0, 16'h0040, '0, fill(8'hA5)});
    foreach (vt[i]) begin
      txn(5, vt[i].we, vt[i].addr, vt[i].data, 0, '0, got);
      if (!vt[i].we) chk($sformatf("vec%0d", i), got, vt[i].exp_rdata);
    end

    // Stray request for 0x0060 in cycle 2 of a read of line 1.
    txn(5, 1'b0, 16'h0020, '0, 2, 16'h0060, got);
    chk("ign_data", got, dz);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("ign_quiet_ack",  {255'b0, ack5},  256'd0);
      chk("ign_quiet_busy", {255'b0, busy5}, 256'd0);
    end
    @(posedge clk); #1;
    txn(5, 1'b0, 16'h0060, '0, 0, '0, got);
    chk("ign_line3", got, 256'd0);

    // Reset in cycle 3 of a write to 0x0080: async clear, no ack, no write.
    drive(5, 1'b1, 1'b1, 16'h0080, fill(8'h3C));
    repeat (3) begin @(posedge clk); #1; drive_idle(5); end
    #2 reset = 1'b1;
    #1;
    chk("async_busy",  {255'b0, busy5}, 256'd0);
    chk("async_ack",   {255'b0, ack5},  256'd0);
    chk("async_rdata", rdata5, 256'd0);
    #2 reset = 1'b0;
    rmod[0] = '0;
    rmod[1] = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_ack", {255'b0, ack5}, 256'd0);
    end
    @(posedge clk); #1;
    txn(5, 1'b0, 16'h0080, '0, 0, '0, got);
    chk("abort_nowrite", got, 256'd0);

    // Latency-1 instance: back-to-back write then read of the same line.
    txn(1, 1'b1, 16'h0100, fill(8'h5A), 0, '0, got);
    txn(1, 1'b0, 16'h0100, '0, 1, 16'h0100, got);
    chk("lat1_raw", got, fill(8'h5A));

    // Randomized traffic against the model, strays included.
    for (int i = 0; i < 200; i++)
      txn(5, 1'($urandom), 16'($urandom), rnd_line(), $urandom_range(0, 5), 16'($urandom), got);
    for (int i = 0; i < 150; i++)
      txn(1, 1'($urandom), 16'($urandom), rnd_line(), $urandom_range(0, 1), 16'($urandom), got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the cache-line transfer protocol driven by the TLB lookup stage: line fills (reads) and line evictions (writes).
- Holds a line-granular backing store and answers one request at a time after a fixed, parameterized latency.
- Drives a busy/ack handshake back to the requester.
- Sits between the TLB stage's memory-request logic and the line bus that feeds the data cache's dataReadFromMem and takes its dataWrittenToMem.

Parameters:
cache_line_width, 256, bits per line transferred
addr_width, 16, width of the byte address presented by the requester
num_bytes_per_line, 32, bytes per line; low log2 of this address bits are the line offset and are ignored
mem_lines, 256, lines in the backing store; must be a power of two
mem_latency, 5, cycles from request acceptance to ack; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_req  input  1  single-cycle request pulse, qualified by mem_busy low
mem_we  input  1  1 = write line (eviction), 0 = read line (fill); sampled with mem_req
mem_addr  input  addr_width  byte address of the line; sampled with mem_req
mem_wdata  input  cache_line_width  line to store; sampled with mem_req
mem_rdata  output  cache_line_width  line read; valid from ack cycle, held until the next read ack
mem_busy  output  1  transaction in flight; requests ignored while high
mem_ack  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high. On reset: state = IDLE, mem_busy = 0, mem_ack = 0, mem_rdata = 0, latency counter = 0, latched request cleared. Array contents are not cleared by reset; the simulation model initialises them to zero.
- Line index = mem_addr[log2(num_bytes_per_line) +: log2(mem_lines)]. Offset bits and address bits above the index are ignored, so addresses alias modulo mem_lines lines.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if mem_req = 1 at a clock edge, latch we, index and wdata, load the counter with mem_latency-1, and go to WAIT. If mem_latency = 1, go directly to ACK. Otherwise stay in IDLE.
  - WAIT: decrement the counter each edge; on the edge where the counter = 1, go to ACK.
  - ACK: go to IDLE unconditionally.
- Timing, with the request sampled at the end of cycle 0:
  - mem_busy = 1 in cycles 1..mem_latency, i.e. in WAIT and ACK.
  - mem_ack = 1 in cycle mem_latency only, i.e. in ACK.
  - Earliest next acceptance is a request in cycle mem_latency+1, giving back-to-back throughput of one line per mem_latency+1 cycles.
- Read: mem_rdata is loaded from array[index] on entry to ACK, so it is valid during the ack cycle. It is held stable until the next read enters ACK. Writes do not change mem_rdata.
- Write: array[index] <= latched wdata at the end of the ACK cycle. A read accepted afterwards returns the new data.
- mem_req while mem_busy = 1 is ignored entirely: no latch and no side effect. mem_we, mem_addr and mem_wdata are don't-care when mem_req = 0.
- mem_req asserted in the ACK cycle is ignored, because busy is high there.
- Reset mid-transaction aborts the transaction: no array write occurs and no ack is issued.
- mem_ack and mem_busy are registered outputs with no combinational path from the inputs.
- The counter is 8 bits wide; mem_latency is never compared against 0.

Test Plan:
- Reset values: assert reset asynchronously between edges -> mem_busy, mem_ack and mem_rdata go to 0 immediately, without waiting for a clock edge.
- Write then read (mem_latency = 5):
  - Write 0xA5A5...A5 to mem_addr = 0x0040 -> busy in cycles 1-5, ack only in cycle 5.
  - Then read 0x0040 -> ack in cycle 5 of the read, mem_rdata = 0xA5A5...A5, held after ack.
- Ignored request while busy: a read of 0x0020 in flight and a second mem_req for 0x0060 in cycle 2 -> exactly one ack, data from line 1, no second transaction.
- Back-to-back and aliasing:
  - Write to 0x0000, then write to 0x2000 with new data requested in cycle 6.
  - Read 0x0000 -> returns the 0x2000 data (index wraps at 256 lines).
  - Offset bits: a read of 0x001F returns line 0.
- Reset mid-write: write to 0x0080 and pulse reset in cycle 3 -> no ack; a later read of 0x0080 returns the prior contents (zero).
- mem_latency = 1 build: request in cycle 0 -> busy and ack both in cycle 1; next request accepted in cycle 2; read-after-write returns the written line.
